// File: rtl/pc_fetch_unit_if.sv
// IF/ID handshake bundle between the fetch stage (master) and decode (slave).
interface pc_fetch_unit_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    output out_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch stage feeding a one-entry IF/ID register, with
// redirect, back-pressure and sticky fault on misaligned/out-of-range fetch.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 88,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   redirect_en,
  input  logic [31:0]            redirect_pc,
  pc_fetch_unit_if.master        ifid,
  output logic                   fault,
  output logic [31:0]            fault_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        ov, ov_nxt;
  logic [31:0] oi, oi_nxt;
  logic [31:0] op, op_nxt;
  logic [31:0] op4, op4_nxt;
  logic        fault_q, fault_nxt;
  logic [31:0] fpc, fpc_nxt;

  logic [32:0] end_addr;
  logic        bad;
  logic        adv;

  // 33-bit end address keeps the range check immune to wrap near 2^32.
  assign end_addr = {1'b0, pc} + 33'd3;
  assign bad      = (pc[1:0] != 2'b00) || (end_addr >= 33'(MEM_BYTES));
  assign adv      = !ov || ifid.out_ready;

  assign imem_addr         = pc;
  assign ifid.out_valid    = ov;
  assign ifid.out_instr    = oi;
  assign ifid.out_pc       = op;
  assign ifid.out_pc_plus4 = op4;
  assign fault             = fault_q;
  assign fault_pc          = fpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      ov      <= 1'b0;
      oi      <= '0;
      op      <= '0;
      op4     <= '0;
      fault_q <= 1'b0;
      fpc     <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ov      <= ov_nxt;
      oi      <= oi_nxt;
      op      <= op_nxt;
      op4     <= op4_nxt;
      fault_q <= fault_nxt;
      fpc     <= fpc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ov_nxt    = ov;
    oi_nxt    = oi;
    op_nxt    = op;
    op4_nxt   = op4;
    fault_nxt = fault_q;
    fpc_nxt   = fpc;

    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (bad) begin
          state_nxt = HALT;
          fault_nxt = 1'b1;
          fpc_nxt   = pc;
          if (ov && ifid.out_ready) ov_nxt = 1'b0;
        end else if (adv) begin
          oi_nxt  = imem_data;
          op_nxt  = pc;
          op4_nxt = pc + PC_STEP;
          ov_nxt  = 1'b1;
          pc_nxt  = pc + PC_STEP;
        end
      end
      HALT: begin
        if (ov && ifid.out_ready) ov_nxt = 1'b0;
      end
      default: state_nxt = BOOT;
    endcase

    // Redirect overrides everything above, including a fault detected this cycle.
    if (redirect_en) begin
      pc_nxt    = redirect_pc & ~32'd1;
      ov_nxt    = 1'b0;
      state_nxt = RUN;
      fault_nxt = 1'b0;
      fpc_nxt   = fpc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench: stimulus pushes the expected fetch stream per redirect/reset,
// a negedge monitor pops it on every IF/ID handshake.
module tb_pc_fetch_unit;
  localparam int unsigned MEM_BYTES = 88;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  pc_fetch_unit_if ifid ();

  pc_fetch_unit #(
    .RESET_PC (RESET_PC),
    .MEM_BYTES(MEM_BYTES),
    .PC_STEP  (32'd4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .ifid       (ifid),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_BYTES/4];

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr[1:0] == 2'b00 && imem_addr < MEM_BYTES)
      imem_data = mem[int'(imem_addr >> 2)];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected delivery order after a (re)start at target: every in-range aligned
  // word from the target upward; the first word that is not becomes the fault address.
  task automatic build_stream(input logic [31:0] target);
    longint unsigned p;
    p = longint'(target & ~32'd1);
    exp_q.delete();
    while ((p % 4 == 0) && (p + 3 < MEM_BYTES)) begin
      exp_q.push_back(32'(p));
      p += 4;
    end
    exp_bad = 32'(p);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic        pv = 1'b0, pr = 1'b0, pskip = 1'b1;
  logic [31:0] pi, pp, pp4;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && !redirect_en) begin
      if (ifid.out_valid && ifid.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc 0x%08h expected none", ifid.out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", ifid.out_pc, e);
          chk("out_pc_plus4", ifid.out_pc_plus4, e + 32'd4);
          chk("out_instr", ifid.out_instr, mem[int'(e >> 2)]);
        end
      end
      if (fault) begin
        chk("fault_pc", fault_pc, exp_bad);
        chk("pending_at_fault", 32'(exp_q.size()),
            (ifid.out_valid && !ifid.out_ready) ? 32'd1 : 32'd0);
      end
      if (pv && !pr && !pskip) begin
        chk("stall_valid", {31'd0, ifid.out_valid}, 32'd1);
        chk("stall_pc", ifid.out_pc, pp);
        chk("stall_pc_plus4", ifid.out_pc_plus4, pp4);
        chk("stall_instr", ifid.out_instr, pi);
      end
    end
    pv    = ifid.out_valid;
    pr    = ifid.out_ready;
    pskip = reset || redirect_en;
    pi    = ifid.out_instr;
    pp    = ifid.out_pc;
    pp4   = ifid.out_pc_plus4;
  end

  initial begin
    for (int i = 0; i < int'(MEM_BYTES / 4); i++) mem[i] = $urandom;
    reset          = 1'b1;
    redirect_en    = 1'b0;
    redirect_pc    = '0;
    ifid.out_ready = 1'b0;
    repeat (2) cyc();

    chk("rst_valid", {31'd0, ifid.out_valid}, 32'd0);
    chk("rst_instr", ifid.out_instr, 32'd0);
    chk("rst_pc", ifid.out_pc, 32'd0);
    chk("rst_pc_plus4", ifid.out_pc_plus4, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);

    build_stream(RESET_PC);
    reset          = 1'b0;
    ifid.out_ready = 1'b1;
    cyc();
    chk("boot_valid", {31'd0, ifid.out_valid}, 32'd0);
    chk("boot_imem_addr", imem_addr, RESET_PC);
    cyc();
    chk("first_valid", {31'd0, ifid.out_valid}, 32'd1);
    chk("first_pc", ifid.out_pc, 32'd0);
    cyc();
    chk("second_pc", ifid.out_pc, 32'd4);
    cyc();
    chk("third_pc", ifid.out_pc, 32'd8);

    ifid.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_imem_addr", imem_addr, 32'd12);
      cyc();
      chk("stall_frozen_pc", ifid.out_pc, 32'd8);
    end
    ifid.out_ready = 1'b1;

    for (int i = 0; i < 10 && !(ifid.out_valid && ifid.out_pc == 32'd16); i++) cyc();
    chk("reach_pc16", ifid.out_pc, 32'd16);

    ifid.out_ready = 1'b0;
    redirect_en    = 1'b1;
    redirect_pc    = 32'h39;
    build_stream(32'h39);
    cyc();
    redirect_en = 1'b0;
    chk("redir_flush_valid", {31'd0, ifid.out_valid}, 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h38);
    ifid.out_ready = 1'b1;
    cyc();
    chk("redir_valid", {31'd0, ifid.out_valid}, 32'd1);
    chk("redir_pc", ifid.out_pc, 32'h38);

    for (int i = 0; i < 40 && !fault; i++) cyc();
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_fault_pc", fault_pc, 32'd88);

    ifid.out_ready = 1'b0;
    redirect_en    = 1'b1;
    redirect_pc    = 32'h32;
    build_stream(32'h32);
    cyc();
    redirect_en    = 1'b0;
    ifid.out_ready = 1'b1;
    chk("mis_fault_clear", {31'd0, fault}, 32'd0);
    chk("mis_imem_addr", imem_addr, 32'h32);
    cyc();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h32);
    chk("mis_valid", {31'd0, ifid.out_valid}, 32'd0);
    cyc();
    chk("mis_pc_hold", imem_addr, 32'h32);

    ifid.out_ready = 1'b0;
    redirect_en    = 1'b1;
    redirect_pc    = 32'h10;
    build_stream(32'h10);
    cyc();
    redirect_en    = 1'b0;
    ifid.out_ready = 1'b1;
    chk("recover_fault", {31'd0, fault}, 32'd0);
    chk("recover_bubble", {31'd0, ifid.out_valid}, 32'd0);
    cyc();
    chk("recover_valid", {31'd0, ifid.out_valid}, 32'd1);
    chk("recover_pc", ifid.out_pc, 32'h10);

    for (int i = 0; i < 20 && !(ifid.out_valid && ifid.out_pc == 32'd40); i++) cyc();
    chk("reach_pc40", ifid.out_pc, 32'd40);
    reset          = 1'b1;
    ifid.out_ready = 1'b0;
    cyc();
    chk("midrst_valid", {31'd0, ifid.out_valid}, 32'd0);
    chk("midrst_imem_addr", imem_addr, RESET_PC);
    chk("midrst_fault", {31'd0, fault}, 32'd0);
    chk("midrst_pc", ifid.out_pc, 32'd0);
    build_stream(RESET_PC);
    reset          = 1'b0;
    ifid.out_ready = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        reset          = 1'b1;
        ifid.out_ready = 1'b0;
        build_stream(RESET_PC);
        cyc();
        reset = 1'b0;
      end else if (r < 7) begin
        logic [31:0] t;
        t = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(72, 100))
                                        : 32'($urandom_range(0, 127));
        redirect_en    = 1'b1;
        redirect_pc    = t;
        ifid.out_ready = 1'b0;
        build_stream(t);
        cyc();
        redirect_en = 1'b0;
      end
      ifid.out_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
